// File: rtl/stfft_pkg.sv
// Shared types and default sizing for the short-time FFT sequencer.
package stfft_pkg;

  localparam int DEFAULT_LGNFFT    = 8;
  localparam int DEFAULT_ALT_DELAY = 22;
  localparam int CNT_W             = 5;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_SAMPLE = 2'd1,
    ST_ALT_WAIT    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/stfft_bin_tracker.sv
// Tracks FFT output bins after the first sync, tags each with its index,
// counts completed frames and flags sync that arrives at the wrong time.
module stfft_bin_tracker
  import stfft_pkg::*;
#(
  parameter int OW     = 18,
  parameter int LGNFFT = DEFAULT_LGNFFT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear_err,
  input  logic              i_fft_ce,
  input  logic              i_fft_sync,
  input  logic [2*OW-1:0]   i_fft_result,
  output logic              o_bin_valid,
  output logic [2*OW-1:0]   o_bin_data,
  output logic [LGNFFT-1:0] o_bin_idx,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_count,
  output logic              o_sync_err
);

  localparam logic [LGNFFT-1:0] LAST_IDX = '1;

  logic              r_armed;
  logic              r_bin_valid;
  logic [2*OW-1:0]   r_bin_data;
  logic [LGNFFT-1:0] r_idx;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic              r_sync_err;

  logic              w_count;
  logic              w_err;
  logic [LGNFFT-1:0] w_next_idx;

  // r_idx always holds the index of the most recently counted bin.
  always_comb begin
    w_count    = 1'b0;
    w_err      = 1'b0;
    w_next_idx = r_idx;
    if (i_fft_ce) begin
      if (i_fft_sync) begin
        w_count    = 1'b1;
        w_next_idx = '0;
        w_err      = r_armed && (r_idx != LAST_IDX);
      end else if (r_armed) begin
        w_count = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next_idx = '0;
          w_err      = 1'b1;
        end else begin
          w_next_idx = r_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_armed       <= 1'b0;
      r_bin_valid   <= 1'b0;
      r_bin_data    <= '0;
      r_idx         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_sync_err    <= 1'b0;
    end else begin
      r_bin_valid  <= w_count;
      r_frame_done <= w_count && (w_next_idx == LAST_IDX);
      if (i_fft_ce && i_fft_sync)
        r_armed <= 1'b1;
      if (w_count) begin
        r_bin_data <= i_fft_result;
        r_idx      <= w_next_idx;
      end
      if (w_count && (w_next_idx == LAST_IDX))
        r_frame_count <= r_frame_count + 16'd1;
      // A fresh error outranks a clear arriving on the same edge.
      if (w_err)
        r_sync_err <= 1'b1;
      else if (i_clear_err)
        r_sync_err <= 1'b0;
    end
  end

  assign o_bin_valid   = r_bin_valid;
  assign o_bin_data    = r_bin_data;
  assign o_bin_idx     = r_idx;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;
  assign o_sync_err    = r_sync_err;

endmodule

// File: rtl/stfft_sequencer.sv
// Short-time FFT front end: paces audio samples into the window/FFT with a
// delayed overlap strobe, and hands FFT bins on through the bin tracker.
module stfft_sequencer
  import stfft_pkg::*;
#(
  parameter int IW        = 14,
  parameter int OW        = 18,
  parameter int LGNFFT    = DEFAULT_LGNFFT,
  parameter int ALT_DELAY = DEFAULT_ALT_DELAY
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [IW-1:0]     i_sample,
  output logic              o_ready,
  output logic              o_ce,
  output logic [IW-1:0]     o_sample,
  output logic              o_alt_ce,
  input  logic              i_fft_ce,
  input  logic              i_fft_sync,
  input  logic [2*OW-1:0]   i_fft_result,
  output logic              o_bin_valid,
  output logic [2*OW-1:0]   o_bin_data,
  output logic [LGNFFT-1:0] o_bin_idx,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_count,
  output logic              o_overrun,
  output logic              o_sync_err
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [CNT_W-1:0] r_countdown;
  logic             r_ce;
  logic             r_alt_ce;
  logic [IW-1:0]    r_sample;
  logic             r_overrun;

  logic             w_accept;
  logic             w_drop;
  logic             w_alt_fire;
  logic             w_clear;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // Leaving ALT_WAIT on the firing edge lets the next sample be taken in the
  // same cycle the overlap strobe is seen, giving a 1+ALT_DELAY cycle period.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_alt_fire   = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_next_state = ST_WAIT_SAMPLE;
          w_clear      = 1'b1;
        end
      end
      ST_WAIT_SAMPLE: begin
        if (i_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_ALT_WAIT;
        end else if (!i_enable) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ALT_WAIT: begin
        w_drop = i_valid && i_enable;
        if (r_countdown <= CNT_W'(1)) begin
          w_alt_fire   = 1'b1;
          w_next_state = i_enable ? ST_WAIT_SAMPLE : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_countdown <= '0;
      r_ce        <= 1'b0;
      r_alt_ce    <= 1'b0;
      r_sample    <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_ce     <= w_accept;
      r_alt_ce <= w_alt_fire;
      if (w_accept)
        r_sample <= i_sample;
      if (w_accept)
        r_countdown <= CNT_W'(ALT_DELAY);
      else if ((r_state == ST_ALT_WAIT) && (r_countdown != '0))
        r_countdown <= r_countdown - 1'b1;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (w_clear)
        r_overrun <= 1'b0;
    end
  end

  assign o_ready   = (r_state == ST_WAIT_SAMPLE);
  assign o_ce      = r_ce;
  assign o_alt_ce  = r_alt_ce;
  assign o_sample  = r_sample;
  assign o_overrun = r_overrun;

  stfft_bin_tracker #(
    .OW     (OW),
    .LGNFFT (LGNFFT)
  ) u_bin_tracker (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear_err   (w_clear),
    .i_fft_ce      (i_fft_ce),
    .i_fft_sync    (i_fft_sync),
    .i_fft_result  (i_fft_result),
    .o_bin_valid   (o_bin_valid),
    .o_bin_data    (o_bin_data),
    .o_bin_idx     (o_bin_idx),
    .o_frame_done  (o_frame_done),
    .o_frame_count (o_frame_count),
    .o_sync_err    (o_sync_err)
  );

endmodule

// File: tb/tb_stfft_sequencer.sv
// Scoreboard bench for stfft_sequencer: expected strobes and bins are queued
// when stimulus is driven and popped when the design produces them.
module tb_stfft_sequencer;

  localparam int IW        = 14;
  localparam int OW        = 18;
  localparam int LGNFFT    = 8;
  localparam int NFFT      = 256;
  localparam int ALT_DELAY = 22;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_enable;
  logic              i_valid;
  logic [IW-1:0]     i_sample;
  logic              o_ready;
  logic              o_ce;
  logic [IW-1:0]     o_sample;
  logic              o_alt_ce;
  logic              i_fft_ce;
  logic              i_fft_sync;
  logic [2*OW-1:0]   i_fft_result;
  logic              o_bin_valid;
  logic [2*OW-1:0]   o_bin_data;
  logic [LGNFFT-1:0] o_bin_idx;
  logic              o_frame_done;
  logic [15:0]       o_frame_count;
  logic              o_overrun;
  logic              o_sync_err;

  typedef struct {
    int            cycle;
    logic [IW-1:0] data;
  } ceExp_t;

  typedef struct {
    int              cycle;
    int              idx;
    logic [2*OW-1:0] data;
    bit              done;
    int              count;
  } binExp_t;

  ceExp_t  ceQ[$];
  int      altQ[$];
  binExp_t binQ[$];

  int      cyc = 0;
  int      total = 0;
  int      bad = 0;
  int      expFrames = 0;

  ceExp_t  monCe;
  int      monAlt;
  binExp_t monBin;

  stfft_sequencer #(
    .IW        (IW),
    .OW        (OW),
    .LGNFFT    (LGNFFT),
    .ALT_DELAY (ALT_DELAY)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_valid       (i_valid),
    .i_sample      (i_sample),
    .o_ready       (o_ready),
    .o_ce          (o_ce),
    .o_sample      (o_sample),
    .o_alt_ce      (o_alt_ce),
    .i_fft_ce      (i_fft_ce),
    .i_fft_sync    (i_fft_sync),
    .i_fft_result  (i_fft_result),
    .o_bin_valid   (o_bin_valid),
    .o_bin_data    (o_bin_data),
    .o_bin_idx     (o_bin_idx),
    .o_frame_done  (o_frame_done),
    .o_frame_count (o_frame_count),
    .o_overrun     (o_overrun),
    .o_sync_err    (o_sync_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic vld, input logic [IW-1:0] smp);
    i_enable = en;
    i_valid  = vld;
    i_sample = smp;
    tick();
  endtask

  task automatic driveBin(input logic sync, input logic [2*OW-1:0] data,
                          input bit counted, input int idx);
    i_fft_ce     = 1'b1;
    i_fft_sync   = sync;
    i_fft_result = data;
    if (counted) begin
      if (idx == NFFT - 1) expFrames = (expFrames + 1) % 65536;
      binQ.push_back('{cycle: cyc + 1, idx: idx, data: data,
                       done: (idx == NFFT - 1), count: expFrames});
    end
    tick();
    i_fft_ce   = 1'b0;
    i_fft_sync = 1'b0;
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  function automatic logic [2*OW-1:0] randBin();
    return (2*OW)'({$urandom(), $urandom()});
  endfunction

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_ready"},      64'(o_ready),       64'd0);
    checkOutput({pfx, "_ce"},         64'(o_ce),          64'd0);
    checkOutput({pfx, "_alt_ce"},     64'(o_alt_ce),      64'd0);
    checkOutput({pfx, "_sample"},     64'(o_sample),      64'd0);
    checkOutput({pfx, "_bin_valid"},  64'(o_bin_valid),   64'd0);
    checkOutput({pfx, "_bin_data"},   64'(o_bin_data),    64'd0);
    checkOutput({pfx, "_bin_idx"},    64'(o_bin_idx),     64'd0);
    checkOutput({pfx, "_frame_done"}, 64'(o_frame_done),  64'd0);
    checkOutput({pfx, "_frame_cnt"},  64'(o_frame_count), 64'd0);
    checkOutput({pfx, "_overrun"},    64'(o_overrun),     64'd0);
    checkOutput({pfx, "_sync_err"},   64'(o_sync_err),    64'd0);
  endtask

  // Output monitor: every strobe or bin must match the head of its queue.
  always @(negedge i_clk) begin
    if (o_ce && o_alt_ce)
      checkOutput("ce_alt_overlap", 64'd1, 64'd0);
    if (o_ce) begin
      if (ceQ.size() == 0) begin
        checkOutput("ce_unexpected", 64'd1, 64'd0);
      end else begin
        monCe = ceQ.pop_front();
        checkOutput("ce_cycle",  64'(cyc),      64'(monCe.cycle));
        checkOutput("ce_sample", 64'(o_sample), 64'(monCe.data));
      end
    end
    if (o_alt_ce) begin
      if (altQ.size() == 0) begin
        checkOutput("alt_unexpected", 64'd1, 64'd0);
      end else begin
        monAlt = altQ.pop_front();
        checkOutput("alt_cycle", 64'(cyc), 64'(monAlt));
      end
    end
    if (o_bin_valid) begin
      if (binQ.size() == 0) begin
        checkOutput("bin_unexpected", 64'd1, 64'd0);
      end else begin
        monBin = binQ.pop_front();
        checkOutput("bin_cycle", 64'(cyc),           64'(monBin.cycle));
        checkOutput("bin_idx",   64'(o_bin_idx),     64'(monBin.idx));
        checkOutput("bin_data",  64'(o_bin_data),    64'(monBin.data));
        checkOutput("bin_done",  64'(o_frame_done),  64'(monBin.done));
        checkOutput("bin_count", 64'(o_frame_count), 64'(monBin.count));
      end
    end else if (o_frame_done) begin
      checkOutput("done_without_valid", 64'd1, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int t0;
    int t1;
    int t3;
    logic [IW-1:0] val;

    i_reset      = 1'b1;
    i_enable     = 1'b0;
    i_valid      = 1'b0;
    i_sample     = '0;
    i_fft_ce     = 1'b0;
    i_fft_sync   = 1'b0;
    i_fft_result = '0;
    repeat (3) tick();
    checkAllZero("reset");
    i_reset = 1'b0;
    tick();

    $display("[TB] bins before first sync are ignored");
    i_fft_ce     = 1'b1;
    i_fft_result = randBin();
    tick();
    i_fft_ce = 1'b0;
    checkOutput("unarmed_valid", 64'(o_bin_valid), 64'd0);
    driveBin(1'b0, randBin(), 1'b0, 0);
    driveBin(1'b0, randBin(), 1'b0, 0);

    $display("[TB] one full frame");
    for (int k = 0; k < NFFT; k++) driveBin(k == 0, randBin(), 1'b1, k);
    tick();
    checkOutput("frame_count_1",   64'(o_frame_count), 64'd1);
    checkOutput("sync_err_clean",  64'(o_sync_err),    64'd0);

    $display("[TB] early sync at bin 100");
    for (int k = 0; k < 100; k++) driveBin(k == 0, randBin(), 1'b1, k);
    driveBin(1'b1, randBin(), 1'b1, 0);
    tick();
    checkOutput("early_sync_err",   64'(o_sync_err),    64'd1);
    checkOutput("early_sync_count", 64'(o_frame_count), 64'd1);
    for (int k = 1; k < NFFT; k++) driveBin(1'b0, randBin(), 1'b1, k);
    tick();
    checkOutput("frame_count_2", 64'(o_frame_count), 64'd2);

    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("enable_clears_sync_err", 64'(o_sync_err), 64'd0);
    checkOutput("wait_ready",             64'(o_ready),    64'd1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("disable_idle_ready", 64'(o_ready), 64'd0);

    $display("[TB] missing sync after last bin");
    driveBin(1'b0, randBin(), 1'b1, 0);
    tick();
    checkOutput("wrap_sync_err", 64'(o_sync_err),    64'd1);
    checkOutput("wrap_count",    64'(o_frame_count), 64'd2);

    $display("[TB] single sample strobe timing");
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("single_ready", 64'(o_ready), 64'd1);
    t = cyc;
    ceQ.push_back('{cycle: t + 1, data: 14'h1234});
    altQ.push_back(t + 1 + ALT_DELAY);
    applyStimulus(1'b1, 1'b1, 14'h1234);
    checkOutput("alt_wait_ready", 64'(o_ready), 64'd0);
    while (cyc < t + 1 + ALT_DELAY) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("after_alt_ready", 64'(o_ready),  64'd1);
    checkOutput("sample_hold",     64'(o_sample), 64'h1234);

    $display("[TB] valid held high");
    t0 = cyc;
    for (int i = 0; i < 2 * (ALT_DELAY + 1) + 1; i++) begin
      val = IW'(256 + i * 37);
      if (i % (ALT_DELAY + 1) == 0) begin
        ceQ.push_back('{cycle: cyc + 1, data: val});
        altQ.push_back(cyc + 1 + ALT_DELAY);
      end
      applyStimulus(1'b1, 1'b1, val);
      if (cyc == t0 + 1) checkOutput("overrun_before", 64'(o_overrun), 64'd0);
      if (cyc == t0 + 2) checkOutput("overrun_set",    64'(o_overrun), 64'd1);
      if (cyc == t0 + 10) checkOutput("held_ready_low", 64'(o_ready),  64'd0);
    end
    while (cyc < t0 + 3 * (ALT_DELAY + 1)) applyStimulus(1'b1, 1'b0, '0);

    $display("[TB] disable during overlap wait");
    t1 = cyc;
    ceQ.push_back('{cycle: t1 + 1, data: 14'h2BCD});
    altQ.push_back(t1 + 1 + ALT_DELAY);
    applyStimulus(1'b1, 1'b1, 14'h2BCD);
    repeat (4) applyStimulus(1'b1, 1'b0, '0);
    while (cyc < t1 + 1 + ALT_DELAY) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("disable_alt_ready", 64'(o_ready), 64'd0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("disable_idle",    64'(o_ready),   64'd0);
    checkOutput("overrun_sticky",  64'(o_overrun), 64'd1);
    checkOutput("disable_sample",  64'(o_sample),  64'h2BCD);

    $display("[TB] reset during overlap wait");
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("enable_clears_overrun", 64'(o_overrun), 64'd0);
    t3 = cyc;
    ceQ.push_back('{cycle: t3 + 1, data: 14'h0ABC});
    applyStimulus(1'b1, 1'b1, 14'h0ABC);
    while (cyc < t3 + 13) applyStimulus(1'b1, 1'b0, '0);
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkAllZero("midreset");
    i_reset = 1'b0;
    repeat (30) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("post_reset_ready", 64'(o_ready), 64'd0);

    checkOutput("ce_queue_empty",  64'(ceQ.size()),  64'd0);
    checkOutput("alt_queue_empty", 64'(altQ.size()), 64'd0);
    checkOutput("bin_queue_empty", 64'(binQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
